// File: rtl/sequential_booth_multiplier_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier: FSM states,
// Booth recode bit positions, the ceil-div used for the cycle count and the recoder.
package sequential_booth_multiplier_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int BOOTH_NEG = 2;
  localparam int BOOTH_TWO = 1;
  localparam int BOOTH_ONE = 0;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Triple is {b[2j+1], b[2j], b[2j-1]}; result is indexed by the BOOTH_* positions.
  function automatic logic [2:0] booth_recode(input logic [2:0] t);
    logic [2:0] r;
    r            = '0;
    r[BOOTH_NEG] = t[2];
    r[BOOTH_TWO] = ~(t[1] ^ t[0]) & (t[2] ^ t[1]);
    r[BOOTH_ONE] = t[1] ^ t[0];
    return r;
  endfunction

endpackage

// File: rtl/sequential_booth_multiplier_booth_pp_gen.sv
// One radix-4 Booth partial product: recodes a triple, selects 0/+-A/+-2A at full
// result width and shifts it into place; disabled digits produce zero.
module sequential_booth_multiplier_booth_pp_gen
  import sequential_booth_multiplier_pkg::*;
#(
  parameter int EXT_W = 18,
  parameter int OUT_W = 32,
  parameter int SH_W  = 5
) (
  input  logic [2:0]       triple,
  input  logic [EXT_W-1:0] a_ext,
  input  logic [SH_W-1:0]  shamt,
  input  logic             en,
  output logic [OUT_W-1:0] pp
);

  localparam logic [OUT_W-1:0] LSB_ONE = OUT_W'(1);

  logic [OUT_W-1:0] a_wide;
  logic [OUT_W-1:0] mag;
  logic [OUT_W-1:0] neg_mag;
  logic [2:0]       code;

  always_comb begin
    for (int i = 0; i < OUT_W; i++) begin
      a_wide[i] = a_ext[(i < EXT_W) ? i : EXT_W - 1];
    end
    code = booth_recode(triple);
    if (code[BOOTH_TWO]) begin
      mag = a_wide << 1;
    end else if (code[BOOTH_ONE]) begin
      mag = a_wide;
    end else begin
      mag = '0;
    end
    // Full-width two's complement makes the negative rows self-correcting.
    neg_mag = ~mag + LSB_ONE;
    pp      = '0;
    if (en) begin
      pp = (code[BOOTH_NEG] ? neg_mag : mag) << shamt;
    end
  end

endmodule

// File: rtl/sequential_booth_multiplier.sv
// Iterative radix-4 Booth multiplier: DIGITS_PER_CYCLE digits per BUSY cycle into a
// carry-save accumulator, one carry-lookahead resolve, then a held result until taken.
module sequential_booth_multiplier
  import sequential_booth_multiplier_pkg::*;
#(
  parameter int INPUT_LENGTH     = 16,
  parameter int OUTPUT_LENGTH    = 32,
  parameter int DIGITS_PER_CYCLE = 2
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic [INPUT_LENGTH-1:0]  iA,
  input  logic [INPUT_LENGTH-1:0]  iB,
  input  logic                     iSigned,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [OUTPUT_LENGTH-1:0] oRes,
  output state_t                   oState
);

  // Handshake: operands transfer on a rising edge with iValid & oReady (only in IDLE);
  // the result transfers on a rising edge with oValid & iReady (only in DONE), and
  // oRes/oValid stay frozen while the consumer stalls.

  localparam int W      = INPUT_LENGTH + 2;
  localparam int D      = W / 2;
  localparam int C      = ceil_div(D, DIGITS_PER_CYCLE);
  localparam int LAST_J = (C - 1) * DIGITS_PER_CYCLE;
  localparam int CNT_W  = $clog2(D + 1);
  localparam int BB_W   = W + 1 + 2 * DIGITS_PER_CYCLE;
  localparam int SH_W   = $clog2(2 * (D + DIGITS_PER_CYCLE));
  localparam int OL     = OUTPUT_LENGTH;

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   a_ext_q, a_ext_d;
  logic [W-1:0]   b_ext_q, b_ext_d;
  logic [OL-1:0]  sum_q, sum_d;
  logic [OL-1:0]  carry_q, carry_d;
  logic [OL-1:0]  res_q, res_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;

  logic [BB_W-1:0] bb;
  logic [2:0]      triple [DIGITS_PER_CYCLE];
  logic [SH_W-1:0] shamt  [DIGITS_PER_CYCLE];
  logic            pp_en  [DIGITS_PER_CYCLE];
  logic [OL-1:0]   pp     [DIGITS_PER_CYCLE];
  logic [OL-1:0]   acc_s, acc_c, csa_s;

  function automatic logic [OL-1:0] cla_add(input logic [OL-1:0] x, input logic [OL-1:0] y);
    logic [OL-1:0] g, p, p0;
    g  = x & y;
    p  = x ^ y;
    p0 = p;
    // Parallel-prefix carry generation; descending i keeps level d-1 values for i-d.
    for (int d = 1; d < OL; d = d * 2) begin
      for (int i = OL - 1; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    return p0 ^ {g[OL-2:0], 1'b0};
  endfunction

  always_comb begin
    bb = {{(2 * DIGITS_PER_CYCLE){b_ext_q[W-1]}}, b_ext_q, 1'b0};
    for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
      triple[k] = bb[2 * (int'(cnt_q) + k) +: 3];
      shamt[k]  = SH_W'(2 * (int'(cnt_q) + k));
      pp_en[k]  = (int'(cnt_q) + k) < D;
    end
  end

  for (genvar k = 0; k < DIGITS_PER_CYCLE; k++) begin : g_pp
    sequential_booth_multiplier_booth_pp_gen #(
      .EXT_W(W),
      .OUT_W(OL),
      .SH_W (SH_W)
    ) u_pp (
      .triple(triple[k]),
      .a_ext (a_ext_q),
      .shamt (shamt[k]),
      .en    (pp_en[k]),
      .pp    (pp[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_ext_d = a_ext_q;
    b_ext_d = b_ext_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    res_d   = res_q;
    ready_d = ready_q;
    valid_d = valid_q;

    acc_s = sum_q;
    acc_c = carry_q;
    for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
      csa_s = acc_s ^ acc_c ^ pp[k];
      acc_c = ((acc_s & acc_c) | (acc_s & pp[k]) | (acc_c & pp[k])) << 1;
      acc_s = csa_s;
    end

    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          a_ext_d = {{2{iSigned & iA[INPUT_LENGTH-1]}}, iA};
          b_ext_d = {{2{iSigned & iB[INPUT_LENGTH-1]}}, iB};
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        sum_d   = acc_s;
        carry_d = acc_c;
        if (int'(cnt_q) == LAST_J) begin
          cnt_d   = '0;
          state_d = S_RESOLVE;
        end else begin
          cnt_d = CNT_W'(int'(cnt_q) + DIGITS_PER_CYCLE);
        end
      end
      S_RESOLVE: begin
        res_d   = cla_add(sum_q, carry_q);
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (iReady) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_ext_q <= '0;
      b_ext_q <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      res_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_ext_q <= a_ext_d;
      b_ext_q <= b_ext_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign oReady = ready_q;
  assign oValid = valid_q;
  assign oRes   = res_q;
  assign oState = state_q;

endmodule

// File: tb/tb_sequential_booth_multiplier.sv
// Bench for the sequential Booth multiplier: a default instance driven by directed and
// random traffic against a timing/product model, plus DPC=3, DPC=1 and 24-bit instances.
module tb_sequential_booth_multiplier;
  import sequential_booth_multiplier_pkg::*;

  localparam int MAIN_C      = 5;
  localparam int AUX_C  [3]  = '{3, 9, 5};
  localparam int AUX_OL [3]  = '{32, 32, 24};

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  // main instance
  logic        m_valid, m_ready_in, m_signed;
  logic [15:0] m_a, m_b;
  logic        m_oready, m_ovalid;
  logic [31:0] m_ores;
  state_t      m_state;

  // auxiliary instances share one driver, consumer always ready
  logic        x_valid, x_signed;
  logic [15:0] x_a, x_b;
  logic        x_oready [3];
  logic        x_ovalid [3];
  logic [31:0] x_ores   [3];
  state_t      x_state  [3];
  logic [23:0] t24_res;
  assign x_ores[2] = {8'h00, t24_res};

  // model of the main instance: one pending product and the cycle it becomes visible
  logic        m_pend;
  int          m_vf;
  logic [31:0] m_exp;

  logic [31:0] exp_q [3][$];
  int          due_q [3][$];

  sequential_booth_multiplier #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .DIGITS_PER_CYCLE(2)) u_dut (
    .iClk(clk), .iRst(rst), .iValid(m_valid), .oReady(m_oready), .iA(m_a), .iB(m_b),
    .iSigned(m_signed), .oValid(m_ovalid), .iReady(m_ready_in), .oRes(m_ores), .oState(m_state));

  sequential_booth_multiplier #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .DIGITS_PER_CYCLE(3)) u_d3 (
    .iClk(clk), .iRst(rst), .iValid(x_valid), .oReady(x_oready[0]), .iA(x_a), .iB(x_b),
    .iSigned(x_signed), .oValid(x_ovalid[0]), .iReady(1'b1), .oRes(x_ores[0]), .oState(x_state[0]));

  sequential_booth_multiplier #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .DIGITS_PER_CYCLE(1)) u_d1 (
    .iClk(clk), .iRst(rst), .iValid(x_valid), .oReady(x_oready[1]), .iA(x_a), .iB(x_b),
    .iSigned(x_signed), .oValid(x_ovalid[1]), .iReady(1'b1), .oRes(x_ores[1]), .oState(x_state[1]));

  sequential_booth_multiplier #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(24), .DIGITS_PER_CYCLE(2)) u_t24 (
    .iClk(clk), .iRst(rst), .iValid(x_valid), .oReady(x_oready[2]), .iA(x_a), .iB(x_b),
    .iSigned(x_signed), .oValid(x_ovalid[2]), .iReady(1'b1), .oRes(t24_res), .oState(x_state[2]));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference ----------------
  function automatic logic [31:0] expect_res(input logic [15:0] a, input logic [15:0] b,
                                              input logic s, input int ol);
    longint pa, pb, pr;
    pa = s ? longint'($signed(a)) : longint'({48'h0, a});
    pb = s ? longint'($signed(b)) : longint'({48'h0, b});
    pr = pa * pb;
    if (ol < 32) pr = pr & ((longint'(1) << ol) - 1);
    return pr[31:0];
  endfunction

  function automatic logic [15:0] pick_op();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h8000;
      1:       v = 16'h7FFF;
      2:       v = 16'hFFFF;
      3:       v = 16'h0000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // model advances on each rising edge using the inputs held since the previous edge
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_pend = 1'b0;
    end else if (m_pend && (cyc - 1) >= m_vf) begin
      if (m_ready_in) m_pend = 1'b0;
    end else if (!m_pend && m_valid) begin
      m_pend = 1'b1;
      m_vf   = cyc + MAIN_C + 1;
      m_exp  = expect_res(m_a, m_b, m_signed, 32);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("main_ready", 32'(m_oready), 32'(!m_pend));
      check("main_valid", 32'(m_ovalid), 32'(m_pend && cyc >= m_vf));
      if (m_pend && cyc >= m_vf) check("main_res", m_ores, m_exp);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (x_ovalid[i]) begin
          if (exp_q[i].size() == 0) begin
            fail_now($sformatf("aux%0d_spurious_valid res=%h", i, x_ores[i]));
          end else begin
            check($sformatf("aux%0d_latency", i), 32'(cyc), 32'(due_q[i][0]));
            check($sformatf("aux%0d_res", i), x_ores[i], exp_q[i][0]);
            void'(exp_q[i].pop_front());
            void'(due_q[i].pop_front());
          end
        end else if (due_q[i].size() > 0 && cyc > due_q[i][0]) begin
          fail_now($sformatf("aux%0d_missing_result due=%0d", i, due_q[i][0]));
          void'(exp_q[i].pop_front());
          void'(due_q[i].pop_front());
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [31:0] res, output int lat);
    int acc;
    @(posedge clk); #1;
    m_valid = 1'b1; m_a = a; m_b = b; m_signed = s; m_ready_in = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    m_valid = 1'b0;
    m_a = 16'($urandom);
    m_b = 16'($urandom);
    lat = -1;
    res = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_ovalid) begin
        lat = cyc - acc;
        res = m_ores;
        break;
      end
    end
  endtask

  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [31:0] want);
    logic [31:0] r;
    int          lat;
    do_op(a, b, s, r, lat);
    check({name, "_res"}, r, want);
    check({name, "_latency"}, 32'(lat), 32'(MAIN_C + 1));
  endtask

  task automatic aux_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("aux%0d_idle_before_op", i),
            32'(x_oready[i] && x_state[i] == S_IDLE), 32'd1);
    end
    x_valid = 1'b1; x_a = a; x_b = b; x_signed = s;
    @(posedge clk); #1;
    x_valid = 1'b0;
    x_a = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      exp_q[i].push_back(expect_res(a, b, s, AUX_OL[i]));
      due_q[i].push_back(cyc + AUX_C[i] + 1);
    end
    repeat (10) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held;
    logic [31:0] r;
    int          lat;
    total = 0; bad = 0; cyc = 0;
    m_pend = 1'b0; m_vf = 0; m_exp = '0;
    rst = 1'b1;
    m_valid = 1'b0; m_ready_in = 1'b1; m_a = '0; m_b = '0; m_signed = 1'b0;
    x_valid = 1'b0; x_a = '0; x_b = '0; x_signed = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(m_oready), 32'd1);
    check("rst_valid", 32'(m_ovalid), 32'd0);
    check("rst_res", m_ores, 32'd0);
    check("rst_state", 32'(m_state), 32'(S_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    check("model_pin_signed", expect_res(16'hFFFD, 16'd5, 1'b1, 32), 32'hFFFFFFF1);
    check("model_pin_trunc24", expect_res(16'hFFFF, 16'hFFFF, 1'b0, 24), 32'h00FE0001);

    directed("neg3x5", 16'hFFFD, 16'd5, 1'b1, 32'hFFFFFFF1);
    directed("min_x_min", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    directed("min_x_max", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
    directed("ffff_unsigned", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    directed("ffff_signed", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);

    // consumer stalls for 5 cycles in DONE; an iValid pulse meanwhile must be ignored
    @(posedge clk); #1;
    m_valid = 1'b1; m_a = 16'h1234; m_b = 16'h5678; m_signed = 1'b0; m_ready_in = 1'b0;
    @(posedge clk); #1;
    m_valid = 1'b0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_ovalid) begin lat = n; break; end
    end
    check("bp_reached_done", 32'(lat >= 0), 32'd1);
    held = m_ores;
    check("bp_res", held, 32'h06260060);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      m_valid = (n == 2);
      m_a = 16'd3; m_b = 16'd3;
      @(negedge clk);
      check("bp_hold_valid", 32'(m_ovalid), 32'd1);
      check("bp_hold_res", m_ores, held);
      check("bp_hold_ready", 32'(m_oready), 32'd0);
    end
    @(posedge clk); #1;
    m_valid = 1'b0; m_ready_in = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_valid", 32'(m_ovalid), 32'd0);
    check("bp_release_ready", 32'(m_oready), 32'd1);

    // asynchronous reset two cycles into BUSY
    @(posedge clk); #1;
    m_valid = 1'b1; m_a = 16'h0F0F; m_b = 16'h00FF; m_signed = 1'b0;
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(m_oready), 32'd1);
    check("arst_valid", 32'(m_ovalid), 32'd0);
    check("arst_res", m_ores, 32'd0);
    check("arst_state", 32'(m_state), 32'(S_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    directed("after_rst_7x9", 16'd7, 16'd9, 1'b0, 32'd63);

    // random traffic with random consumer stalls, checked every cycle by the model
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      m_valid    = 1'($urandom_range(0, 1));
      m_a        = pick_op();
      m_b        = pick_op();
      m_signed   = 1'($urandom_range(0, 1));
      m_ready_in = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    m_valid = 1'b0; m_ready_in = 1'b1;
    repeat (15) @(posedge clk);

    // DPC=3, DPC=1 and 24-bit truncation instances
    aux_op(16'hFFFD, 16'd5, 1'b1);
    aux_op(16'hFFFF, 16'hFFFF, 1'b0);
    aux_op(16'h8000, 16'h8000, 1'b1);
    for (int n = 0; n < 600; n++) begin
      aux_op(pick_op(), pick_op(), 1'($urandom_range(0, 1)));
    end
    repeat (5) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("aux%0d_drained", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
